// File: rtl/wram_arbiter_pkg.sv
// rtl/wram_arbiter_pkg.sv - shared mcd types for the word-RAM arbiter
//
// Package mcd: arbiter state and owner enums, grant bit positions,
// the fixed full-word write mask and a write-mask helper.
package mcd;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        SUB  = 2'd1,
        ASIC = 2'd2,
        DMA  = 2'd3
    } owner_e;

    // Bit positions inside the one-hot grant vector.
    localparam int GNT_SUB  = 0;
    localparam int GNT_ASIC = 1;
    localparam int GNT_DMA  = 2;

    localparam logic [3:0] FULL_MASK = 4'b1111;

    // A read drives no bank write enables.
    function automatic logic [3:0] wr_mask(input logic we, input logic [3:0] mask);
        return we ? mask : 4'b0000;
    endfunction

endpackage

// File: rtl/wram_arbiter_if.sv
// rtl/wram_arbiter_if.sv - requester and bank bus of the word-RAM arbiter
//
// Signals: sub_sync strobe; per-requester req/we/addr/din/ack (sub, asic,
// dma); sub_mask; pm; rd_data; sub_halt; bank side mem_addr/mem_din/
// mem_mask/mem_mode/mem_dout.
// Modports: master = requesters and bank model, slave = arbiter.
interface wram_arbiter_if;
    logic        sub_sync;
    logic        sub_req;
    logic        asic_req;
    logic        dma_req;
    logic        sub_we;
    logic        asic_we;
    logic        dma_we;
    logic [15:0] sub_addr;
    logic [15:0] asic_addr;
    logic [15:0] dma_addr;
    logic [15:0] sub_din;
    logic [15:0] asic_din;
    logic [15:0] dma_din;
    logic [3:0]  sub_mask;
    logic [1:0]  pm;
    logic        sub_ack;
    logic        asic_ack;
    logic        dma_ack;
    logic [15:0] rd_data;
    logic        sub_halt;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic [3:0]  mem_mask;
    logic [1:0]  mem_mode;
    logic [15:0] mem_dout;

    modport master (
        output sub_sync, sub_req, asic_req, dma_req, sub_we, asic_we, dma_we,
               sub_addr, asic_addr, dma_addr, sub_din, asic_din, dma_din,
               sub_mask, pm, mem_dout,
        input  sub_ack, asic_ack, dma_ack, rd_data, sub_halt,
               mem_addr, mem_din, mem_mask, mem_mode
    );

    modport slave (
        input  sub_sync, sub_req, asic_req, dma_req, sub_we, asic_we, dma_we,
               sub_addr, asic_addr, dma_addr, sub_din, asic_din, dma_din,
               sub_mask, pm, mem_dout,
        output sub_ack, asic_ack, dma_ack, rd_data, sub_halt,
               mem_addr, mem_din, mem_mask, mem_mode
    );
endinterface

// File: rtl/wram_arb_pick.sv
// rtl/wram_arb_pick.sv - combinational priority pick for the word-RAM arbiter
//
// Ports: sub_req_i, asic_req_i, dma_req_i - pending requests
//        starve_i  - sub CPU has lost the maximum number of arbitrations
//        grant_o   - one-hot grant, bit order from mcd::GNT_*
module wram_arb_pick
    import mcd::*;
(
    input  logic       sub_req_i,
    input  logic       asic_req_i,
    input  logic       dma_req_i,
    input  logic       starve_i,
    output logic [2:0] grant_o
);

    // DMA > ASIC > SUB, with a starved sub CPU jumping the queue.
    always_comb begin
        grant_o = 3'b000;
        if (starve_i && sub_req_i) begin
            grant_o[GNT_SUB] = 1'b1;
        end else if (dma_req_i) begin
            grant_o[GNT_DMA] = 1'b1;
        end else if (asic_req_i) begin
            grant_o[GNT_ASIC] = 1'b1;
        end else if (sub_req_i) begin
            grant_o[GNT_SUB] = 1'b1;
        end
    end

endmodule

// File: rtl/wram_arbiter.sv
// rtl/wram_arbiter.sv - three-requester word-RAM bank arbiter
//
// Parameter: SUB_WAIT_MAX - lost arbitrations before the sub CPU is forced (1-15)
// Ports: clk_asic - clock, rising edge
//        cd_rst   - synchronous active-high reset
//        bus      - requester/bank bus (wram_arbiter_if.slave)
//        halt_cnt - cycles with sub_halt=1, saturating; only with WRAM_ARB_STATS_EN
// Each access walks IDLE -> ADDR -> DATA, one step per sub_sync strobe.
module wram_arbiter
    import mcd::*;
#(
    parameter int unsigned SUB_WAIT_MAX = 4
) (
    input  logic                 clk_asic,
    input  logic                 cd_rst,
`ifdef WRAM_ARB_STATS_EN
    output logic [15:0]          halt_cnt,
`endif
    wram_arbiter_if.slave        bus
);

    localparam logic [3:0] WAIT_MAX = 4'(SUB_WAIT_MAX);

    arb_state_e  state_q;
    owner_e      owner_q;
    logic [3:0]  starve_q;
    logic [15:0] mem_addr_q;
    logic [15:0] mem_din_q;
    logic [3:0]  mem_mask_q;
    logic [1:0]  mem_mode_q;
    logic [15:0] rd_data_q;
    logic        sub_ack_q;
    logic        asic_ack_q;
    logic        dma_ack_q;
    logic        sub_halt_q;
    logic        starve;
    logic [2:0]  grant;

    assign starve = (starve_q == WAIT_MAX);

    wram_arb_pick u_pick (
        .sub_req_i  (bus.sub_req),
        .asic_req_i (bus.asic_req),
        .dma_req_i  (bus.dma_req),
        .starve_i   (starve),
        .grant_o    (grant)
    );

    always_ff @(posedge clk_asic) begin
        if (cd_rst) begin
            state_q    <= IDLE;
            owner_q    <= NONE;
            starve_q   <= 4'd0;
            mem_addr_q <= 16'h0000;
            mem_din_q  <= 16'h0000;
            mem_mask_q <= 4'b0000;
            mem_mode_q <= 2'b00;
            rd_data_q  <= 16'h0000;
            sub_ack_q  <= 1'b0;
            asic_ack_q <= 1'b0;
            dma_ack_q  <= 1'b0;
            sub_halt_q <= 1'b0;
        end else begin
            // Acks are single-cycle pulses even when the next strobe is far away.
            sub_ack_q  <= 1'b0;
            asic_ack_q <= 1'b0;
            dma_ack_q  <= 1'b0;
            // The sub CPU stays halted through its own access and is released
            // the cycle after its ack, when rd_data already holds its word.
            sub_halt_q <= bus.sub_req & ~sub_ack_q;

            if (bus.sub_sync) begin
                case (state_q)
                    IDLE: begin
                        if (grant != 3'b000) begin
                            state_q <= ADDR;
                            if (grant[GNT_DMA]) begin
                                owner_q    <= DMA;
                                mem_addr_q <= bus.dma_addr;
                                mem_din_q  <= bus.dma_din;
                                mem_mask_q <= wr_mask(bus.dma_we, FULL_MASK);
                                mem_mode_q <= 2'b00;
                            end else if (grant[GNT_ASIC]) begin
                                owner_q    <= ASIC;
                                mem_addr_q <= bus.asic_addr;
                                mem_din_q  <= bus.asic_din;
                                mem_mask_q <= wr_mask(bus.asic_we, FULL_MASK);
                                mem_mode_q <= bus.pm;
                            end else begin
                                owner_q    <= SUB;
                                mem_addr_q <= bus.sub_addr;
                                mem_din_q  <= bus.sub_din;
                                mem_mask_q <= wr_mask(bus.sub_we, bus.sub_mask);
                                mem_mode_q <= 2'b00;
                            end
                            if (grant[GNT_SUB]) begin
                                starve_q <= 4'd0;
                            end else if (bus.sub_req && (starve_q < WAIT_MAX)) begin
                                starve_q <= starve_q + 4'd1;
                            end
                        end
                    end
                    ADDR: begin
                        // Write enables are live for exactly the ADDR step.
                        state_q    <= DATA;
                        mem_mask_q <= 4'b0000;
                    end
                    DATA: begin
                        state_q   <= IDLE;
                        owner_q   <= NONE;
                        rd_data_q <= bus.mem_dout;
                        case (owner_q)
                            SUB:     sub_ack_q  <= 1'b1;
                            ASIC:    asic_ack_q <= 1'b1;
                            DMA:     dma_ack_q  <= 1'b1;
                            default: ;
                        endcase
                    end
                    default: begin
                        state_q <= IDLE;
                        owner_q <= NONE;
                    end
                endcase
            end
        end
    end

    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_din_q;
    assign bus.mem_mask = mem_mask_q;
    assign bus.mem_mode = mem_mode_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.sub_ack  = sub_ack_q;
    assign bus.asic_ack = asic_ack_q;
    assign bus.dma_ack  = dma_ack_q;
    assign bus.sub_halt = sub_halt_q;

`ifdef WRAM_ARB_STATS_EN
    logic [15:0] halt_cnt_q;

    always_ff @(posedge clk_asic) begin
        if (cd_rst) begin
            halt_cnt_q <= 16'h0000;
        end else if (sub_halt_q && (halt_cnt_q != 16'hFFFF)) begin
            halt_cnt_q <= halt_cnt_q + 16'd1;
        end
    end

    assign halt_cnt = halt_cnt_q;
`endif

endmodule
